regfile_write_arbiter: RTL and testbench

Shares the register file's single write port between the core writeback path and a debug/loader port. After reset, it sequences a clear sweep that zeroes every register. It sits directly in front of the register file's RD/WriteData/RegWrite inputs and enforces x0 write suppression. The core has priority, with a bounded-starvation guarantee for the debug port.

---
 rtl/regfile_write_arbiter.sv | 103 ++++++++++
 tb/tb_regfile_write_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter in front of the register file: post-reset clear sweep,
// core-priority arbitration with bounded debug starvation, x0 suppression.
module regfile_write_arbiter #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 32,
  parameter int NUM_REGS   = 32,
  parameter int STARVE_LIM = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_rd,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_stall,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_rd,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic              dbg_err,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_rd,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              busy
);

  localparam logic [0:0]        ST_CLEAR = 1'b0;
  localparam logic [0:0]        ST_RUN   = 1'b1;
  localparam logic [ADDR_W:0]   NREGS    = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
  localparam logic [3:0]        LIM      = 4'(STARVE_LIM);

  logic [0:0]        state;
  logic [ADDR_W-1:0] idx;
  logic [3:0]        starve_cnt;

  logic core_eff, dbg_eff, forced, run, dbg_win, core_win;

  function automatic logic idx_ok(input logic [ADDR_W-1:0] a);
    return (a != '0) && ({1'b0, a} < NREGS);
  endfunction

  always_comb begin
    run      = (state == ST_RUN) && !reset;
    core_eff = core_we && idx_ok(core_rd);
    dbg_eff  = idx_ok(dbg_rd);
    forced   = dbg_req && (starve_cnt == LIM);
    dbg_win  = run && dbg_req && (forced || !core_eff);
    core_win = run && core_eff && !dbg_win;
  end

  always_comb begin
    rf_we      = 1'b0;
    rf_rd      = '0;
    rf_wdata   = '0;
    core_stall = 1'b0;
    dbg_ack    = 1'b0;
    dbg_err    = 1'b0;
    busy       = 1'b0;
    if (reset) begin
      core_stall = 1'b1;
      busy       = 1'b1;
    end else if (state == ST_CLEAR) begin
      rf_we      = 1'b1;
      rf_rd      = idx;
      core_stall = 1'b1;
      busy       = 1'b1;
    end else if (dbg_win) begin
      dbg_ack    = 1'b1;
      core_stall = core_eff;
      if (dbg_eff) begin
        rf_we    = 1'b1;
        rf_rd    = dbg_rd;
        rf_wdata = dbg_wdata;
      end else begin
        dbg_err  = 1'b1;
      end
    end else if (core_win) begin
      rf_we    = 1'b1;
      rf_rd    = core_rd;
      rf_wdata = core_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_CLEAR;
      idx        <= '0;
      starve_cnt <= '0;
    end else if (state == ST_CLEAR) begin
      idx        <= idx + 1'b1;
      starve_cnt <= '0;
      if (idx == LAST_IDX)
        state <= ST_RUN;
    end else begin
      // In RUN a pending request that did not win was necessarily beaten by the core.
      if (!dbg_req || dbg_win)
        starve_cnt <= '0;
      else if (starve_cnt != LIM)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: expected port values are queued
// with each cycle's stimulus and compared mid-cycle.
module tb_regfile_write_arbiter;

  logic        clock;
  logic        reset;
  logic        core_we;
  logic [5:0]  core_rd;
  logic [31:0] core_wdata;
  logic        core_stall;
  logic        dbg_req;
  logic [5:0]  dbg_rd;
  logic [31:0] dbg_wdata;
  logic        dbg_ack;
  logic        dbg_err;
  logic        rf_we;
  logic [5:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic        busy;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct packed {
    logic        we;
    logic [5:0]  rd;
    logic [31:0] wd;
    logic        stall;
    logic        ack;
    logic        err;
    logic        busy;
    logic        chk_addr;
  } exp_t;

  exp_t sb[$];

  regfile_write_arbiter #(
    .ADDR_W(6), .DATA_W(32), .NUM_REGS(32), .STARVE_LIM(4)
  ) dut (
    .clock(clock), .reset(reset),
    .core_we(core_we), .core_rd(core_rd), .core_wdata(core_wdata),
    .core_stall(core_stall),
    .dbg_req(dbg_req), .dbg_rd(dbg_rd), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_err(dbg_err),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Queue the expectation for the current inputs, sample mid-cycle, advance.
  task automatic cyc(input string tag, input logic we, input logic [5:0] rd,
                     input logic [31:0] wd, input logic stall, input logic ack,
                     input logic err, input logic bsy, input logic chk_addr);
    exp_t e;
    sb.push_back('{we: we, rd: rd, wd: wd, stall: stall, ack: ack, err: err,
                   busy: bsy, chk_addr: chk_addr});
    #3;
    e = sb.pop_front();
    check({tag, ".rf_we"},      64'(rf_we),      64'(e.we));
    check({tag, ".core_stall"}, 64'(core_stall), 64'(e.stall));
    check({tag, ".dbg_ack"},    64'(dbg_ack),    64'(e.ack));
    check({tag, ".dbg_err"},    64'(dbg_err),    64'(e.err));
    check({tag, ".busy"},       64'(busy),       64'(e.busy));
    if (e.chk_addr) begin
      check({tag, ".rf_rd"},    64'(rf_rd),      64'(e.rd));
      check({tag, ".rf_wdata"}, 64'(rf_wdata),   64'(e.wd));
    end
    @(posedge clock);
    #1;
  endtask

  task automatic sweep(input string tag, input int unsigned n);
    for (int unsigned i = 0; i < n; i++)
      cyc($sformatf("%s[%0d]", tag, i), 1'b1, 6'(i), 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; core_we = 1'b0; core_rd = '0; core_wdata = '0;
    dbg_req = 1'b0; dbg_rd = '0; dbg_wdata = '0;
    @(posedge clock);
    #1;

    for (int unsigned i = 0; i < 2; i++)
      cyc($sformatf("reset[%0d]", i), 1'b0, 6'd0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    reset = 1'b0;
    core_we = 1'b1; core_rd = 6'd5; core_wdata = 32'hDEADBEEF;
    sweep("sweep", 32);

    cyc("core_only", 1'b1, 6'd5, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    core_rd = 6'd7; core_wdata = 32'h0000_0077;
    dbg_req = 1'b1; dbg_rd = 6'd9; dbg_wdata = 32'h12;
    for (int unsigned i = 0; i < 4; i++)
      cyc($sformatf("starve[%0d]", i), 1'b1, 6'd7, 32'h77, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc("forced_dbg", 1'b1, 6'd9, 32'h12, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    dbg_req = 1'b0;
    cyc("core_resume", 1'b1, 6'd7, 32'h77, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    core_rd = 6'd0; core_wdata = 32'hFFFF_FFFF;
    dbg_req = 1'b1; dbg_rd = 6'd3; dbg_wdata = 32'h33;
    cyc("x0_core_dbg", 1'b1, 6'd3, 32'h33, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

    core_we = 1'b0;
    dbg_rd = 6'd0;
    cyc("dbg_idx0", 1'b0, 6'd0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    dbg_rd = 6'd40;
    cyc("dbg_idx40", 1'b0, 6'd0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    dbg_req = 1'b0;
    core_we = 1'b1; core_rd = 6'd40;
    cyc("core_idx40", 1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    core_we = 1'b0;
    cyc("idle", 1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    core_rd = 6'd31; core_wdata = 32'hA5A5_0031; core_we = 1'b1;
    cyc("core_rd31", 1'b1, 6'd31, 32'hA5A5_0031, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    core_we = 1'b0;

    reset = 1'b1;
    cyc("reset2", 1'b0, 6'd0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    reset = 1'b0;
    dbg_req = 1'b1; dbg_rd = 6'd9; dbg_wdata = 32'h99;
    sweep("sweep_part", 10);
    reset = 1'b1;
    cyc("reset_mid", 1'b0, 6'd0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    reset = 1'b0;
    sweep("sweep_restart", 32);
    cyc("dbg_after_sweep", 1'b1, 6'd9, 32'h99, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    dbg_req = 1'b0;
    cyc("idle_end", 1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
